// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths, the zero register, write-back FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

    localparam int MIPS_DATA_W = 32;
    localparam int MIPS_ADDR_W = 5;
    localparam int REG_ZERO    = 0;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_stage_if.sv
// EX/MEM -> WB bundle, data-memory read response, and register-file write-back outputs.
// Latency: n/a (wiring only).
// Backpressure: stall_out flows back to the upstream stages.
interface wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
);
    logic              valid_in;
    logic              RegWriteM;
    logic              MemtoRegM;
    logic [ADDR_W-1:0] write_addr_M;
    logic [DATA_W-1:0] ALUout_M;
    logic              dmem_rvalid;
    logic [DATA_W-1:0] dmem_rdata;
    logic              RegWriteW;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              stall_out;
    logic              load_err;
    logic [CNT_W-1:0]  instret;

    // Upstream pipeline + memory side
    modport master (
        output valid_in, RegWriteM, MemtoRegM, write_addr_M, ALUout_M,
        output dmem_rvalid, dmem_rdata,
        input  RegWriteW, wb_addr, wb_data, stall_out, load_err, instret
    );

    // Write-back stage side
    modport slave (
        input  valid_in, RegWriteM, MemtoRegM, write_addr_M, ALUout_M,
        input  dmem_rvalid, dmem_rdata,
        output RegWriteW, wb_addr, wb_data, stall_out, load_err, instret
    );
endinterface

// File: rtl/wb_timeout_ctr.sv
// Counts stall cycles spent on one outstanding load; flags when the budget is used up.
// Latency: expired is combinational from the registered count.
// Backpressure: none; clr has priority over en.
module wb_timeout_ctr #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise step while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/wb_stage.sv
// MEM/WB register, ALU/load result select, load wait with timeout, retired-instruction count.
// Latency: 1 cycle for ALU ops and zero-wait loads; loads retire the edge after dmem_rvalid.
// Backpressure: stall_out (combinational) holds IF..MEM while a load waits for its data.
module wb_stage
    import mips_pkg::*;
#(
    parameter int DATA_W      = MIPS_DATA_W,
    parameter int ADDR_W      = MIPS_ADDR_W,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 32
) (
    input  logic       CLK,
    input  logic       RST_N,
    wb_stage_if.slave  bus
);

    wb_state_t         state_q, state_d;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              load_err_q, load_err_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic              ld_we_q, ld_we_d;
    logic              stall;
    logic              to_clr, to_en, to_expired;

    // The count tracks stall cycles for the current load, the presentation cycle included,
    // so expiry lands after exactly TIMEOUT_CYC stalled cycles.
    wb_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .clr     (to_clr),
        .en      (to_en),
        .expired (to_expired)
    );

    // Next-state, MEM/WB register contents and stall request
    always_comb begin
        state_d    = state_q;
        regwrite_d = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        load_err_d = load_err_q;
        instret_d  = instret_q;
        ld_addr_d  = ld_addr_q;
        ld_we_d    = ld_we_q;
        stall      = 1'b0;
        to_clr     = 1'b1;
        to_en      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.valid_in) begin
                    if (!bus.MemtoRegM || bus.dmem_rvalid) begin
                        regwrite_d = bus.RegWriteM && (bus.write_addr_M != ADDR_W'(REG_ZERO));
                        wb_addr_d  = bus.write_addr_M;
                        wb_data_d  = bus.MemtoRegM ? bus.dmem_rdata : bus.ALUout_M;
                        instret_d  = instret_q + CNT_W'(1);
                    end else begin
                        ld_addr_d = bus.write_addr_M;
                        ld_we_d   = bus.RegWriteM;
                        state_d   = WAIT_LOAD;
                        stall     = 1'b1;
                        to_clr    = 1'b0;
                        to_en     = 1'b1;
                    end
                end
            end
            WAIT_LOAD: begin
                to_clr = 1'b0;
                stall  = !bus.dmem_rvalid;
                if (bus.dmem_rvalid) begin
                    regwrite_d = ld_we_q && (ld_addr_q != ADDR_W'(REG_ZERO));
                    wb_addr_d  = ld_addr_q;
                    wb_data_d  = bus.dmem_rdata;
                    instret_d  = instret_q + CNT_W'(1);
                    state_d    = IDLE;
                end else if (to_expired) begin
                    // Abandon the load: retire it as failed without a register write
                    load_err_d = 1'b1;
                    instret_d  = instret_q + CNT_W'(1);
                    state_d    = IDLE;
                end else begin
                    to_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and MEM/WB registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            regwrite_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            load_err_q <= 1'b0;
            instret_q  <= '0;
            ld_addr_q  <= '0;
            ld_we_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            regwrite_q <= regwrite_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            load_err_q <= load_err_d;
            instret_q  <= instret_d;
            ld_addr_q  <= ld_addr_d;
            ld_we_q    <= ld_we_d;
        end
    end

    // Stall is forced low while reset is asserted, even if a load sits in EX/MEM
    assign bus.stall_out = stall && RST_N;
    assign bus.RegWriteW = regwrite_q;
    assign bus.wb_addr   = wb_addr_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.load_err  = load_err_q;
    assign bus.instret   = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    logic CLK;
    logic RST_N;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_stall;
    int   n_wr;

    wb_stage_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) bus ();

    wb_stage #(.DATA_W(32), .ADDR_W(5), .TIMEOUT_CYC(16), .CNT_W(32)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r,
                         input logic [4:0] a, input logic [31:0] alu,
                         input logic rv, input logic [31:0] rd);
        bus.valid_in     = v;
        bus.RegWriteM    = rw;
        bus.MemtoRegM    = m2r;
        bus.write_addr_M = a;
        bus.ALUout_M     = alu;
        bus.dmem_rvalid  = rv;
        bus.dmem_rdata   = rd;
        #1;
    endtask

    initial begin
        RST_N = 1'b0;
        drive(0, 0, 0, 5'd0, 32'h0, 0, 32'h0);
        chk("rst_regwrite", bus.RegWriteW, 0);
        chk("rst_addr",     bus.wb_addr,   0);
        chk("rst_data",     bus.wb_data,   0);
        chk("rst_load_err", bus.load_err,  0);
        chk("rst_instret",  bus.instret,   0);
        chk("rst_stall",    bus.stall_out, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        tick();

        // 1. ALU op to r8
        drive(1, 1, 0, 5'd8, 32'h0000_1234, 0, 32'h0);
        chk("alu_stall", bus.stall_out, 0);
        tick();
        chk("alu_regwrite", bus.RegWriteW, 1);
        chk("alu_addr",     bus.wb_addr,   8);
        chk("alu_data",     bus.wb_data,   32'h1234);
        chk("alu_instret",  bus.instret,   1);
        drive(0, 0, 0, 5'd0, 32'h0, 0, 32'h0);
        chk("idle_stall", bus.stall_out, 0);
        tick();
        chk("idle_regwrite", bus.RegWriteW, 0);
        chk("idle_addr_hold", bus.wb_addr, 8);
        chk("idle_data_hold", bus.wb_data, 32'h1234);

        // 2. zero-wait load to r9
        drive(1, 1, 1, 5'd9, 32'h0000_0040, 1, 32'hDEAD_BEEF);
        chk("zw_stall", bus.stall_out, 0);
        tick();
        chk("zw_regwrite", bus.RegWriteW, 1);
        chk("zw_addr",     bus.wb_addr,   9);
        chk("zw_data",     bus.wb_data,   32'hDEAD_BEEF);
        chk("zw_instret",  bus.instret,   2);
        drive(0, 0, 0, 5'd0, 32'h0, 0, 32'h0);
        tick();

        // 3. load with data 3 cycles later, to r10
        drive(1, 1, 1, 5'd10, 32'h0000_0080, 0, 32'h0);
        chk("ld3_stall_c0", bus.stall_out, 1);
        tick();
        chk("ld3_stall_c1", bus.stall_out, 1);
        chk("ld3_nowr_c1",  bus.RegWriteW, 0);
        tick();
        chk("ld3_stall_c2", bus.stall_out, 1);
        chk("ld3_nowr_c2",  bus.RegWriteW, 0);
        tick();
        chk("ld3_nowr_c3",  bus.RegWriteW, 0);
        drive(1, 1, 1, 5'd10, 32'h0000_0080, 1, 32'h0000_CAFE);
        chk("ld3_stall_c3", bus.stall_out, 0);
        tick();
        chk("ld3_regwrite", bus.RegWriteW, 1);
        chk("ld3_addr",     bus.wb_addr,   10);
        chk("ld3_data",     bus.wb_data,   32'hCAFE);
        chk("ld3_instret",  bus.instret,   3);
        drive(0, 0, 0, 5'd0, 32'h0, 0, 32'h0);
        chk("ld3_stall_after", bus.stall_out, 0);
        tick();
        chk("ld3_pulse_end", bus.RegWriteW, 0);

        // 4. write to r0 is suppressed but still retires
        drive(1, 1, 0, 5'd0, 32'hFFFF_FFFF, 0, 32'h0);
        tick();
        chk("r0_regwrite", bus.RegWriteW, 0);
        chk("r0_data",     bus.wb_data,   32'hFFFF_FFFF);
        chk("r0_instret",  bus.instret,   4);
        drive(0, 0, 0, 5'd0, 32'h0, 0, 32'h0);
        tick();

        // 5. load that never gets data: 16 stalled cycles then load_err
        drive(1, 1, 1, 5'd11, 32'h0000_00C0, 0, 32'h0);
        n_stall = 0;
        n_wr    = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.stall_out) break;
            n_stall++;
            tick();
            if (bus.RegWriteW) n_wr++;
            if (bus.load_err) drive(0, 0, 0, 5'd0, 32'h0, 0, 32'h0);
        end
        chk("to_stall_cycles", n_stall, 16);
        chk("to_no_write",     n_wr,    0);
        chk("to_load_err",     bus.load_err, 1);
        chk("to_instret",      bus.instret,  5);
        chk("to_addr_hold",    bus.wb_addr,  0);
        drive(1, 1, 0, 5'd12, 32'h0000_0055, 0, 32'h0);
        chk("to_idle_stall", bus.stall_out, 0);
        tick();
        chk("post_to_regwrite", bus.RegWriteW, 1);
        chk("post_to_addr",     bus.wb_addr,   12);
        chk("post_to_data",     bus.wb_data,   32'h55);
        chk("post_to_instret",  bus.instret,   6);
        chk("post_to_err_sticky", bus.load_err, 1);
        drive(0, 0, 0, 5'd0, 32'h0, 0, 32'h0);
        tick();

        // 6. reset while waiting on a load
        drive(1, 1, 1, 5'd13, 32'h0000_0100, 0, 32'h0);
        tick();
        tick();
        chk("rw_stall_pre", bus.stall_out, 1);
        RST_N = 1'b0;
        #1;
        chk("rw_stall",    bus.stall_out, 0);
        chk("rw_regwrite", bus.RegWriteW, 0);
        chk("rw_instret",  bus.instret,   0);
        chk("rw_load_err", bus.load_err,  0);
        drive(0, 0, 0, 5'd0, 32'h0, 0, 32'h0);
        RST_N = 1'b1;
        tick();
        drive(0, 0, 0, 5'd0, 32'h0, 1, 32'h0000_0BAD);
        chk("late_rv_stall", bus.stall_out, 0);
        tick();
        chk("late_rv_regwrite", bus.RegWriteW, 0);
        chk("late_rv_instret",  bus.instret,   0);
        chk("late_rv_data",     bus.wb_data,   0);
        drive(0, 0, 0, 5'd0, 32'h0, 0, 32'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
